// File: rtl/gps_pkg.sv
// Shared GPS tracking definitions: power width, default correlator widths,
// early/late integrator state encoding and a saturating adder.
package gps_pkg;

  localparam int unsigned POWER_W      = 29;
  localparam int unsigned SAMPLE_W_DEF = 4;
  localparam int unsigned ACC_W_DEF    = 16;

  typedef enum logic {
    SYNC  = 1'b0,
    INTEG = 1'b1
  } el_state_t;

  // Signed add of two 32-bit operands, clamped to the range of a w-bit
  // signed value (w <= 31), so accumulators never wrap.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int unsigned        w
  );
    logic signed [32:0] sum;
    logic signed [32:0] vmax;
    logic signed [32:0] vmin;
    sum  = {a[31], a} + {b[31], b};
    vmax = (33'sd1 <<< (w - 1)) - 33'sd1;
    vmin = -(33'sd1 <<< (w - 1));
    if (sum > vmax) begin
      sat_add = vmax[31:0];
    end else if (sum < vmin) begin
      sat_add = vmin[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/el_power_accum_if.sv
// Sample-in / power-out bundle between code generator, correlator back end
// and DLL filter. master drives samples, slave (the correlator) drives powers.
interface el_power_accum_if
  import gps_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] i_sample;
  logic signed [SAMPLE_W-1:0] q_sample;
  logic                       code_e;
  logic                       code_l;
  logic                       dump;
  logic [POWER_W-1:0]         p_e;
  logic [POWER_W-1:0]         p_l;
  logic                       p_valid;
  logic                       lost;
  logic                       locked;

  modport master (
    output sample_valid, i_sample, q_sample, code_e, code_l, dump,
    input  p_e, p_l, p_valid, lost, locked
  );

  modport slave (
    input  sample_valid, i_sample, q_sample, code_e, code_l, dump,
    output p_e, p_l, p_valid, lost, locked
  );
endinterface

// File: rtl/el_power_calc.sv
// I^2+Q^2 power of one correlator branch: register the squares, then
// register the shifted, 29-bit saturated sum. Output holds between strobes.
module el_power_calc
  import gps_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned POW_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic signed [ACC_W-1:0] i_i,
  input  logic signed [ACC_W-1:0] i_q,
  output logic [POWER_W-1:0]      o_pow,
  output logic                    o_vld
);
  localparam int unsigned SQ_W = 2 * ACC_W;
  localparam logic [SQ_W:0] POW_MAX = (SQ_W + 1)'({POWER_W{1'b1}});

  logic signed [SQ_W-1:0] w_prod_i;
  logic signed [SQ_W-1:0] w_prod_q;
  logic [SQ_W:0]          w_sum;
  logic [SQ_W:0]          w_shift;
  logic [POWER_W-1:0]     w_sat;

  logic [SQ_W-1:0]        r_sq_i;
  logic [SQ_W-1:0]        r_sq_q;
  logic                   r_vld1;
  logic [POWER_W-1:0]     r_pow;
  logic                   r_vld2;

  // Squares of signed values are non-negative and fit SQ_W bits even for -2^(ACC_W-1).
  always_comb begin
    w_prod_i = i_i * i_i;
    w_prod_q = i_q * i_q;
    w_sum    = {1'b0, r_sq_i} + {1'b0, r_sq_q};
    w_shift  = w_sum >> POW_SHIFT;
    w_sat    = (w_shift > POW_MAX) ? POW_MAX[POWER_W-1:0] : w_shift[POWER_W-1:0];
  end

  // Stage 1: register the two squares.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sq_i <= '0;
      r_sq_q <= '0;
      r_vld1 <= 1'b0;
    end else begin
      r_vld1 <= i_vld;
      if (i_vld) begin
        r_sq_i <= w_prod_i;
        r_sq_q <= w_prod_q;
      end
    end
  end

  // Stage 2: register the saturated power and its strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pow  <= '0;
      r_vld2 <= 1'b0;
    end else begin
      r_vld2 <= r_vld1;
      if (r_vld1) begin
        r_pow <= w_sat;
      end
    end
  end

  assign o_pow = r_pow;
  assign o_vld = r_vld2;

endmodule

// File: rtl/el_power_accum.sv
// Early/late integrate-and-dump back end: accumulates code-wiped I/Q per
// epoch, captures totals at dump and hands them to two power calculators.
module el_power_accum
  import gps_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned POW_SHIFT   = 4,
  parameter int unsigned MAX_SAMPLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  el_power_accum_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(MAX_SAMPLES + 1);

  el_state_t               r_state;
  logic signed [ACC_W-1:0] r_ie, r_qe, r_il, r_ql;
  logic signed [ACC_W-1:0] r_d_ie, r_d_qe, r_d_il, r_d_ql;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_dump_vld;
  logic                    r_lost;

  logic signed [31:0]      w_i_ext, w_q_ext;
  logic signed [ACC_W-1:0] w_ie_nxt, w_qe_nxt, w_il_nxt, w_ql_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_hit_max;
  logic [POWER_W-1:0]      w_pe, w_pl;
  logic                    w_pe_vld, w_pl_vld;

  // Next accumulator values including this cycle's sample; negation is done
  // on the widened sample so the most negative input negates cleanly.
  always_comb begin
    w_i_ext   = 32'(bus.i_sample);
    w_q_ext   = 32'(bus.q_sample);
    w_ie_nxt  = r_ie;
    w_qe_nxt  = r_qe;
    w_il_nxt  = r_il;
    w_ql_nxt  = r_ql;
    w_cnt_nxt = r_cnt + CNT_W'(1);
    w_hit_max = bus.sample_valid && (w_cnt_nxt == CNT_W'(MAX_SAMPLES));
    if (bus.sample_valid) begin
      w_ie_nxt = ACC_W'(sat_add(32'(r_ie), bus.code_e ? w_i_ext : -w_i_ext, ACC_W));
      w_qe_nxt = ACC_W'(sat_add(32'(r_qe), bus.code_e ? w_q_ext : -w_q_ext, ACC_W));
      w_il_nxt = ACC_W'(sat_add(32'(r_il), bus.code_l ? w_i_ext : -w_i_ext, ACC_W));
      w_ql_nxt = ACC_W'(sat_add(32'(r_ql), bus.code_l ? w_q_ext : -w_q_ext, ACC_W));
    end
  end

  // Lock FSM, accumulators, sample counter and dump capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SYNC;
      r_ie       <= '0;
      r_qe       <= '0;
      r_il       <= '0;
      r_ql       <= '0;
      r_d_ie     <= '0;
      r_d_qe     <= '0;
      r_d_il     <= '0;
      r_d_ql     <= '0;
      r_cnt      <= '0;
      r_dump_vld <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_dump_vld <= 1'b0;
      r_lost     <= 1'b0;
      case (r_state)
        SYNC: begin
          if (bus.dump) begin
            r_state <= INTEG;
          end
        end
        INTEG: begin
          if (bus.dump) begin
            r_d_ie     <= w_ie_nxt;
            r_d_qe     <= w_qe_nxt;
            r_d_il     <= w_il_nxt;
            r_d_ql     <= w_ql_nxt;
            r_dump_vld <= 1'b1;
            r_ie       <= '0;
            r_qe       <= '0;
            r_il       <= '0;
            r_ql       <= '0;
            r_cnt      <= '0;
          end else if (w_hit_max) begin
            r_lost  <= 1'b1;
            r_state <= SYNC;
            r_ie    <= '0;
            r_qe    <= '0;
            r_il    <= '0;
            r_ql    <= '0;
            r_cnt   <= '0;
          end else begin
            r_ie <= w_ie_nxt;
            r_qe <= w_qe_nxt;
            r_il <= w_il_nxt;
            r_ql <= w_ql_nxt;
            if (bus.sample_valid) begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  el_power_calc #(
    .ACC_W     (ACC_W),
    .POW_SHIFT (POW_SHIFT)
  ) u_calc_e (
    .clk   (clk),
    .rst   (rst),
    .i_vld (r_dump_vld),
    .i_i   (r_d_ie),
    .i_q   (r_d_qe),
    .o_pow (w_pe),
    .o_vld (w_pe_vld)
  );

  el_power_calc #(
    .ACC_W     (ACC_W),
    .POW_SHIFT (POW_SHIFT)
  ) u_calc_l (
    .clk   (clk),
    .rst   (rst),
    .i_vld (r_dump_vld),
    .i_i   (r_d_il),
    .i_q   (r_d_ql),
    .o_pow (w_pl),
    .o_vld (w_pl_vld)
  );

  assign bus.p_e     = w_pe;
  assign bus.p_l     = w_pl;
  assign bus.p_valid = w_pe_vld & w_pl_vld;
  assign bus.lost    = r_lost;
  assign bus.locked  = (r_state == INTEG);

endmodule

// File: tb/tb_el_power_accum.sv
// Directed bench for el_power_accum. Three instances share one stimulus:
// A (POW_SHIFT=4, MAX=8192), B (POW_SHIFT=0, MAX=8192), C (POW_SHIFT=4, MAX=4).
module tb_el_power_accum;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sv  = 1'b0;
  logic signed [3:0] is  = '0;
  logic signed [3:0] qs  = '0;
  logic              ce  = 1'b0;
  logic              cl  = 1'b0;
  logic              dmp = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  el_power_accum_if #(.SAMPLE_W(4)) ifa ();
  el_power_accum_if #(.SAMPLE_W(4)) ifb ();
  el_power_accum_if #(.SAMPLE_W(4)) ifc ();

  assign ifa.sample_valid = sv;  assign ifb.sample_valid = sv;  assign ifc.sample_valid = sv;
  assign ifa.i_sample     = is;  assign ifb.i_sample     = is;  assign ifc.i_sample     = is;
  assign ifa.q_sample     = qs;  assign ifb.q_sample     = qs;  assign ifc.q_sample     = qs;
  assign ifa.code_e       = ce;  assign ifb.code_e       = ce;  assign ifc.code_e       = ce;
  assign ifa.code_l       = cl;  assign ifb.code_l       = cl;  assign ifc.code_l       = cl;
  assign ifa.dump         = dmp; assign ifb.dump         = dmp; assign ifc.dump         = dmp;

  el_power_accum #(.SAMPLE_W(4), .ACC_W(16), .POW_SHIFT(4), .MAX_SAMPLES(8192)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  el_power_accum #(.SAMPLE_W(4), .ACC_W(16), .POW_SHIFT(0), .MAX_SAMPLES(8192)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb));
  el_power_accum #(.SAMPLE_W(4), .ACC_W(16), .POW_SHIFT(4), .MAX_SAMPLES(4)) u_dut_c (
    .clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    step(); step();
    rst = 1'b0;
    check("rst_p_e",     32'(ifa.p_e), 0);
    check("rst_p_l",     32'(ifa.p_l), 0);
    check("rst_p_valid", 32'(ifa.p_valid), 0);
    check("rst_lost",    32'(ifa.lost), 0);
    check("rst_locked",  32'(ifa.locked), 0);

    // First dump locks; 10 samples i=3, code_l alternating; dump
    dmp = 1'b1; step(); dmp = 1'b0;
    check("t1_locked", 32'(ifa.locked), 1);
    for (int k = 0; k < 10; k++) begin
      sv = 1'b1; is = 4'sd3; qs = 4'sd0; ce = 1'b1; cl = ((k % 2) == 0);
      step();
    end
    sv = 1'b0;
    dmp = 1'b1; step(); dmp = 1'b0;
    check("t1_pv_edge1", 32'(ifa.p_valid), 0);
    step();
    check("t1_pv_edge2", 32'(ifa.p_valid), 0);
    step();
    check("t1_pv_edge3", 32'(ifa.p_valid), 1);
    check("t1_a_p_e",    32'(ifa.p_e), 56);
    check("t1_a_p_l",    32'(ifa.p_l), 0);
    check("t1_b_p_e",    32'(ifb.p_e), 900);
    check("t1_locked2",  32'(ifa.locked), 1);
    step();
    check("t1_pv_single", 32'(ifa.p_valid), 0);
    step();
    check("t1_hold_p_e", 32'(ifa.p_e), 56);

    // Pre-lock samples are discarded
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sv = 1'b1; is = 4'sd7; qs = 4'sd0; ce = 1'b1; cl = 1'b1;
      step();
    end
    sv = 1'b0;
    dmp = 1'b1; step(); dmp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_no_pv_first_dump", 32'(ifa.p_valid), 0);
    end
    check("t2_locked", 32'(ifa.locked), 1);
    dmp = 1'b1; step(); dmp = 1'b0;
    step(); step();
    check("t2_pv",    32'(ifa.p_valid), 1);
    check("t2_b_p_e", 32'(ifb.p_e), 0);
    check("t2_b_p_l", 32'(ifb.p_l), 0);

    // Accumulator saturation: I_E=32767, Q_E=-32768, I_L=-32768, Q_L=32767
    rst = 1'b1; step(); rst = 1'b0;
    dmp = 1'b1; step(); dmp = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      sv = 1'b1; is = 4'sd7; qs = -4'sd7; ce = 1'b1; cl = 1'b0;
      step();
    end
    sv = 1'b0;
    dmp = 1'b1; step(); dmp = 1'b0;
    step(); step();
    check("t3_pv",    32'(ifa.p_valid), 1);
    check("t3_a_p_e", 32'(ifa.p_e), 134213632);
    check("t3_a_p_l", 32'(ifa.p_l), 134213632);
    check("t3_b_p_e", 32'(ifb.p_e), 536870911);
    check("t3_b_p_l", 32'(ifb.p_l), 536870911);

    // Loss of lock on the MAX_SAMPLES-th sample (instance C, MAX=4)
    rst = 1'b1; step(); rst = 1'b0;
    dmp = 1'b1; step(); dmp = 1'b0;
    check("t4_locked", 32'(ifc.locked), 1);
    sv = 1'b1; is = 4'sd2; qs = 4'sd0; ce = 1'b1; cl = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_no_lost_early", 32'(ifc.lost), 0);
    end
    step();
    check("t4_lost",        32'(ifc.lost), 1);
    check("t4_unlocked",    32'(ifc.locked), 0);
    check("t4_no_pv",       32'(ifc.p_valid), 0);
    sv = 1'b0;
    step();
    check("t4_lost_pulse",  32'(ifc.lost), 0);
    step(); step();
    check("t4_no_pv_later", 32'(ifc.p_valid), 0);
    // Same again, dump on the 4th sample
    dmp = 1'b1; step(); dmp = 1'b0;
    sv = 1'b1;
    step(); step(); step();
    dmp = 1'b1; step();
    check("t4b_no_lost", 32'(ifc.lost), 0);
    check("t4b_locked",  32'(ifc.locked), 1);
    sv = 1'b0; dmp = 1'b0;
    step(); step();
    check("t4b_pv",  32'(ifc.p_valid), 1);
    check("t4b_p_e", 32'(ifc.p_e), 4);
    check("t4b_p_l", 32'(ifc.p_l), 4);

    // Back-to-back dumps, each with one sample i=q=1
    rst = 1'b1; step(); rst = 1'b0;
    dmp = 1'b1; step();
    sv = 1'b1; is = 4'sd1; qs = 4'sd1; ce = 1'b1; cl = 1'b0;
    step(); step(); step();
    check("t5_pv0",    32'(ifa.p_valid), 1);
    check("t5_a_p_e",  32'(ifa.p_e), 0);
    check("t5_b_p_e0", 32'(ifb.p_e), 2);
    check("t5_b_p_l0", 32'(ifb.p_l), 2);
    sv = 1'b0; dmp = 1'b0;
    step();
    check("t5_pv1",    32'(ifa.p_valid), 1);
    check("t5_b_p_e1", 32'(ifb.p_e), 2);
    step();
    check("t5_pv2",    32'(ifb.p_valid), 1);
    check("t5_b_p_l2", 32'(ifb.p_l), 2);
    step();
    check("t5_pv_end", 32'(ifa.p_valid), 0);

    // Reset one cycle after a dump edge discards the in-flight result
    sv = 1'b1; is = 4'sd3; qs = 4'sd0; ce = 1'b1; cl = 1'b1;
    step();
    dmp = 1'b1; step();
    sv = 1'b0; dmp = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_b_p_e",   32'(ifb.p_e), 0);
    check("t6_b_p_l",   32'(ifb.p_l), 0);
    check("t6_unlocked", 32'(ifb.locked), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_no_pv", 32'(ifb.p_valid), 0);
    end
    check("t6_b_p_e_end", 32'(ifb.p_e), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
